// File: rtl/alu_issue_stage_if.sv
// Handshake bundles around the ALU issue stage.
//   issue_in_if  : decoded-instruction bus from the decoder into the stage.
//   issue_out_if : head-entry operands and side-band fields out of the stage.
// In both interfaces, the master modport is the side that drives valid.

interface issue_in_if;
   localparam int XLEN = 32;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic [4:0]      in_rs1_idx;
   logic [4:0]      in_rs2_idx;
   logic [4:0]      in_rd;
   logic            in_wen;
   logic [1:0]      in_src1_sel;
   logic [1:0]      in_src2_sel;
   logic [3:0]      in_func;

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rs1_idx, in_rs2_idx,
             in_rd, in_wen, in_src1_sel, in_src2_sel, in_func,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rs1_idx, in_rs2_idx,
             in_rd, in_wen, in_src1_sel, in_src2_sel, in_func,
      output in_ready
   );
endinterface

interface issue_out_if;
   localparam int XLEN = 32;

   logic [XLEN-1:0] alu_rs1;
   logic [XLEN-1:0] alu_rs2;
   logic [3:0]      alu_func;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_store_data;
   logic [4:0]      out_rd;
   logic            out_wen;

   modport master (
      output alu_rs1, alu_rs2, alu_func, out_valid, out_pc, out_store_data,
             out_rd, out_wen,
      input  out_ready
   );

   modport slave (
      input  alu_rs1, alu_rs2, alu_func, out_valid, out_pc, out_store_data,
             out_rd, out_wen,
      output out_ready
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: writeback bypass, operand select, and a two-entry
// head/skid buffer. in_ready is a flop, so no combinational path runs from
// out_ready back to the decoder. The ALU and consumer see only registered
// head fields.

module alu_issue_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   issue_in_if.slave   i_up,
   issue_out_if.master o_dn
);

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] store_data;
      logic [3:0]      func;
      logic [4:0]      rd;
      logic            wen;
   } entry_t;

   // Encoding mirrors {S.valid, H.valid}. S valid with H empty is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic            r_in_ready;
   entry_t          r_head;
   entry_t          r_skid;
   entry_t          w_new;
   logic [XLEN-1:0] w_rs1_eff;
   logic [XLEN-1:0] w_rs2_eff;
   logic            w_accept;
   logic            w_drain;
   logic            w_load_h_new;
   logic            w_load_h_skid;
   logic            w_load_s;

   // Bypass the writeback result, then select operands and build the entry.
   always_comb begin
      // NOTE: each always_comb output gets a default first, so no path leaves
      // it unassigned and infers a latch.
      w_new     = '0;
      w_rs1_eff = i_up.in_rs1;
      w_rs2_eff = i_up.in_rs2;
      if (wb_valid && (wb_rd != 5'd0) && (wb_rd == i_up.in_rs1_idx)) w_rs1_eff = wb_data;
      if (wb_valid && (wb_rd != 5'd0) && (wb_rd == i_up.in_rs2_idx)) w_rs2_eff = wb_data;

      unique case (i_up.in_src1_sel)
         2'b00:   w_new.op1 = w_rs1_eff;
         2'b01:   w_new.op1 = i_up.in_pc;
         default: w_new.op1 = '0;
      endcase

      unique case (i_up.in_src2_sel)
         2'b00:   w_new.op2 = w_rs2_eff;
         2'b01:   w_new.op2 = i_up.in_imm;
         2'b10:   w_new.op2 = 32'd4;
         default: w_new.op2 = '0;
      endcase

      w_new.pc         = i_up.in_pc;
      w_new.store_data = w_rs2_eff;
      w_new.func       = i_up.in_func;
      w_new.rd         = i_up.in_rd;
      w_new.wen        = i_up.in_wen && (i_up.in_rd != 5'd0);
   end

   // Compute the next buffer state and which registers to load.
   always_comb begin
      w_next_state  = r_state;
      w_load_h_new  = 1'b0;
      w_load_h_skid = 1'b0;
      w_load_s      = 1'b0;
      w_accept      = i_up.in_valid && r_in_ready;
      w_drain       = (r_state != ST_EMPTY) && o_dn.out_ready;

      if (flush) begin
         w_next_state = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_next_state = ST_ONE;
                  w_load_h_new = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  w_load_h_new = 1'b1;
               end else if (w_accept) begin
                  w_next_state = ST_FULL;
                  w_load_s     = 1'b1;
               end else if (w_drain) begin
                  w_next_state = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so no accept can occur.
               if (w_drain) begin
                  w_next_state  = ST_ONE;
                  w_load_h_skid = 1'b1;
               end
            end
            default: w_next_state = ST_EMPTY;
         endcase
      end
   end

   // Register the state and in_ready. in_ready tracks !S.valid for the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment, so all flops
      // sample pre-edge values and simulation matches the hardware.
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != ST_FULL);
      end
   end

   // Load the entry registers. They clear on reset because outputs have defined reset values.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: these are ordinary flops, not a RAM, so resetting them is
      // cheap and gives the head outputs a known value after reset.
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_h_new)       r_head <= w_new;
         else if (w_load_h_skid) r_head <= r_skid;
         if (w_load_s)           r_skid <= w_new;
      end
   end

   assign i_up.in_ready       = r_in_ready;
   assign o_dn.out_valid      = r_state[0];
   assign o_dn.alu_rs1        = r_head.op1;
   assign o_dn.alu_rs2        = r_head.op2;
   assign o_dn.alu_func       = r_head.func;
   assign o_dn.out_pc         = r_head.pc;
   assign o_dn.out_store_data = r_head.store_data;
   assign o_dn.out_rd         = r_head.rd;
   assign o_dn.out_wen        = r_head.wen;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: table-driven operand and bypass vectors,
// plus directed sequences for backpressure, flush and asynchronous reset.

module tb_alu_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   issue_in_if  u_in ();
   issue_out_if u_out ();

   alu_issue_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .i_up     (u_in.slave),
      .o_dn     (u_out.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  idx1, idx2, rd;
      logic        wen;
      logic [1:0]  s1, s2;
      logic [3:0]  func;
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic [31:0] e_op1, e_op2, e_sd;
      logic [3:0]  e_func;
      logic [4:0]  e_rd;
      logic        e_wen;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      u_in.in_pc       = v.pc;
      u_in.in_rs1      = v.rs1;
      u_in.in_rs2      = v.rs2;
      u_in.in_imm      = v.imm;
      u_in.in_rs1_idx  = v.idx1;
      u_in.in_rs2_idx  = v.idx2;
      u_in.in_rd       = v.rd;
      u_in.in_wen      = v.wen;
      u_in.in_src1_sel = v.s1;
      u_in.in_src2_sel = v.s2;
      u_in.in_func     = v.func;
      wb_valid         = v.wbv;
      wb_rd            = v.wbrd;
      wb_data          = v.wbd;
   endtask

   // Simple entry that passes rs1 straight through. The tag identifies order.
   task automatic drive_tag(input logic [31:0] tag);
      u_in.in_pc       = 32'h1234;
      u_in.in_rs1      = tag;
      u_in.in_rs2      = 32'h66;
      u_in.in_imm      = '0;
      u_in.in_rs1_idx  = 5'd1;
      u_in.in_rs2_idx  = 5'd2;
      u_in.in_rd       = 5'd9;
      u_in.in_wen      = 1'b1;
      u_in.in_src1_sel = 2'b00;
      u_in.in_src2_sel = 2'b00;
      u_in.in_func     = 4'h5;
      wb_valid         = 1'b0;
      wb_rd            = '0;
      wb_data          = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".out_valid"},  {31'd0, u_out.out_valid}, 32'd0);
      check({tag, ".in_ready"},   {31'd0, u_in.in_ready},   32'd1);
      check({tag, ".alu_rs1"},    u_out.alu_rs1,            32'd0);
      check({tag, ".alu_rs2"},    u_out.alu_rs2,            32'd0);
      check({tag, ".alu_func"},   {28'd0, u_out.alu_func},  32'd0);
      check({tag, ".out_pc"},     u_out.out_pc,             32'd0);
      check({tag, ".store_data"}, u_out.out_store_data,     32'd0);
      check({tag, ".out_rd"},     {27'd0, u_out.out_rd},    32'd0);
      check({tag, ".out_wen"},    {31'd0, u_out.out_wen},   32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // pc rs1 rs2 imm | idx1 idx2 rd wen | s1 s2 func | wbv wbrd wbd | e_op1 e_op2 e_sd e_func e_rd e_wen
      vecs[0] = '{32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1, 2'b00, 2'b00, 4'h0,
                  1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'h0, 5'd10, 1'b1};
      vecs[1] = '{32'h104, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd11, 1'b1, 2'b00, 2'b00, 4'h8,
                  1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'h8, 5'd11, 1'b1};
      vecs[2] = '{32'h80000000, 32'h1, 32'h22, 32'd0, 5'd1, 5'd2, 5'd12, 1'b1, 2'b01, 2'b10, 4'h2,
                  1'b0, 5'd0, 32'd0, 32'h80000000, 32'd4, 32'h22, 4'h2, 5'd12, 1'b1};
      vecs[3] = '{32'h108, 32'h1, 32'h22, 32'hFFFFF800, 5'd1, 5'd2, 5'd13, 1'b1, 2'b11, 2'b01, 4'h3,
                  1'b0, 5'd0, 32'd0, 32'd0, 32'hFFFFF800, 32'h22, 4'h3, 5'd13, 1'b1};
      vecs[4] = '{32'h10C, 32'h11, 32'h33, 32'd0, 5'd3, 5'd5, 5'd14, 1'b1, 2'b00, 2'b00, 4'h0,
                  1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h33, 32'h33, 4'h0, 5'd14, 1'b1};
      vecs[5] = '{32'h110, 32'h11, 32'h33, 32'd0, 5'd0, 5'd5, 5'd15, 1'b1, 2'b00, 2'b00, 4'h0,
                  1'b1, 5'd0, 32'hDEADBEEF, 32'h11, 32'h33, 32'h33, 4'h0, 5'd15, 1'b1};
      vecs[6] = '{32'h114, 32'h99, 32'h44, 32'h10, 5'd2, 5'd7, 5'd16, 1'b1, 2'b00, 2'b01, 4'h1,
                  1'b1, 5'd7, 32'hCAFEF00D, 32'h99, 32'h10, 32'hCAFEF00D, 4'h1, 5'd16, 1'b1};
      vecs[7] = '{32'h118, 32'h55, 32'h66, 32'd0, 5'd1, 5'd2, 5'd0, 1'b1, 2'b10, 2'b11, 4'h4,
                  1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h66, 4'h4, 5'd0, 1'b0};
      vecs[8] = '{32'h11C, 32'h77, 32'h88, 32'd0, 5'd4, 5'd6, 5'd17, 1'b0, 2'b00, 2'b00, 4'h5,
                  1'b0, 5'd4, 32'hDEADBEEF, 32'h77, 32'h88, 32'h88, 4'h5, 5'd17, 1'b0};
      vecs[9] = '{32'h120, 32'h1, 32'hAA, 32'd0, 5'd1, 5'd0, 5'd18, 1'b1, 2'b00, 2'b00, 4'h6,
                  1'b1, 5'd0, 32'h0000BEEF, 32'h1, 32'hAA, 32'hAA, 4'h6, 5'd18, 1'b1};

      rst_n           = 1'b0;
      flush           = 1'b0;
      u_in.in_valid   = 1'b0;
      u_out.out_ready = 1'b1;
      drive_tag(32'h0);
      #12;
      check_reset_outputs("reset");

      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back issue with out_ready=1: one accept per cycle, in_ready stays high.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive_vec(vecs[i]);
         u_in.in_valid = 1'b1;
         step();
         check($sformatf("v%0d.out_valid", i),  {31'd0, u_out.out_valid}, 32'd1);
         check($sformatf("v%0d.in_ready", i),   {31'd0, u_in.in_ready},   32'd1);
         check($sformatf("v%0d.alu_rs1", i),    u_out.alu_rs1,            vecs[i].e_op1);
         check($sformatf("v%0d.alu_rs2", i),    u_out.alu_rs2,            vecs[i].e_op2);
         check($sformatf("v%0d.alu_func", i),   {28'd0, u_out.alu_func},  {28'd0, vecs[i].e_func});
         check($sformatf("v%0d.out_pc", i),     u_out.out_pc,             vecs[i].pc);
         check($sformatf("v%0d.store_data", i), u_out.out_store_data,     vecs[i].e_sd);
         check($sformatf("v%0d.out_rd", i),     {27'd0, u_out.out_rd},    {27'd0, vecs[i].e_rd});
         check($sformatf("v%0d.out_wen", i),    {31'd0, u_out.out_wen},   {31'd0, vecs[i].e_wen});
      end
      @(negedge clk);
      u_in.in_valid = 1'b0;
      step();
      check("drain.out_valid", {31'd0, u_out.out_valid}, 32'd0);

      // Backpressure: three entries against out_ready=0, then release.
      @(negedge clk);
      u_out.out_ready = 1'b0;
      drive_tag(32'd1);
      u_in.in_valid = 1'b1;
      step();
      check("bp1.out_valid", {31'd0, u_out.out_valid}, 32'd1);
      check("bp1.alu_rs1",   u_out.alu_rs1,            32'd1);
      check("bp1.in_ready",  {31'd0, u_in.in_ready},   32'd1);
      @(negedge clk);
      drive_tag(32'd2);
      step();
      check("bp2.in_ready",  {31'd0, u_in.in_ready},   32'd0);
      check("bp2.alu_rs1",   u_out.alu_rs1,            32'd1);
      @(negedge clk);
      drive_tag(32'd3);
      step();
      check("bp3.in_ready",  {31'd0, u_in.in_ready},   32'd0);
      check("bp3.alu_rs1",   u_out.alu_rs1,            32'd1);
      check("bp3.out_valid", {31'd0, u_out.out_valid}, 32'd1);
      @(negedge clk);
      u_out.out_ready = 1'b1;
      step();
      check("bp4.alu_rs1",   u_out.alu_rs1,            32'd2);
      check("bp4.in_ready",  {31'd0, u_in.in_ready},   32'd1);
      step();
      check("bp5.alu_rs1",   u_out.alu_rs1,            32'd3);
      check("bp5.out_valid", {31'd0, u_out.out_valid}, 32'd1);
      @(negedge clk);
      u_in.in_valid = 1'b0;
      step();
      check("bp6.out_valid", {31'd0, u_out.out_valid}, 32'd0);

      // Flush while FULL, with in_valid high on the flush cycle.
      @(negedge clk);
      u_out.out_ready = 1'b0;
      drive_tag(32'hA);
      u_in.in_valid = 1'b1;
      step();
      @(negedge clk);
      drive_tag(32'hB);
      step();
      check("fl.full_in_ready", {31'd0, u_in.in_ready}, 32'd0);
      @(negedge clk);
      drive_tag(32'hC);
      flush = 1'b1;
      step();
      check("fl.out_valid", {31'd0, u_out.out_valid}, 32'd0);
      check("fl.in_ready",  {31'd0, u_in.in_ready},   32'd1);
      @(negedge clk);
      flush           = 1'b0;
      u_in.in_valid   = 1'b0;
      u_out.out_ready = 1'b1;
      step();
      check("fl.no_ghost", {31'd0, u_out.out_valid}, 32'd0);

      // Flush from EMPTY drops an accept that would otherwise succeed.
      @(negedge clk);
      drive_tag(32'hD);
      u_in.in_valid = 1'b1;
      flush         = 1'b1;
      step();
      check("fl2.out_valid", {31'd0, u_out.out_valid}, 32'd0);
      @(negedge clk);
      flush         = 1'b0;
      u_in.in_valid = 1'b0;
      step();
      check("fl2.no_ghost", {31'd0, u_out.out_valid}, 32'd0);

      // Asynchronous reset while FULL, asserted between clock edges.
      @(negedge clk);
      u_out.out_ready = 1'b0;
      drive_tag(32'h55);
      u_in.in_valid = 1'b1;
      step();
      @(negedge clk);
      drive_tag(32'h56);
      step();
      check("ar.full_in_ready", {31'd0, u_in.in_ready}, 32'd0);
      check("ar.pre_rd",        {27'd0, u_out.out_rd},  32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst_n           = 1'b1;
      u_out.out_ready = 1'b1;
      drive_tag(32'h77);
      step();
      check("ar.first_valid", {31'd0, u_out.out_valid}, 32'd1);
      check("ar.first_rs1",   u_out.alu_rs1,            32'h77);
      @(negedge clk);
      u_in.in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage directly upstream of the 32-bit ALU. It accepts decoded instructions over a valid/ready handshake, selects and bypasses operands, and holds them in a two-entry skid buffer. The head entry drives the ALU operand and function inputs and passes side-band fields (rd, wen, pc, store data) to the downstream consumer of the ALU result. The buffer gives full throughput with a registered `in_ready`.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous kill of all buffered entries
- in_valid / in_ready  in / out  1 / 1  upstream handshake
- in_pc, in_rs1, in_rs2, in_imm  in  32 each  PC, register-file read data, immediate
- in_rs1_idx, in_rs2_idx, in_rd  in  5 each  source and destination register indices
- in_wen  in  1  destination write enable
- in_src1_sel  in  2  00 rs1, 01 pc, 10 zero, 11 zero
- in_src2_sel  in  2  00 rs2, 01 imm, 10 constant 4, 11 zero
- in_func  in  4  ALU function code, passed through unmodified
- wb_valid, wb_rd, wb_data  in  1, 5, 32  writeback bypass source
- alu_rs1, alu_rs2  out  32  head-entry operands to ALU
- alu_func  out  4  head-entry function code
- out_valid / out_ready  out / in  1 / 1  downstream handshake
- out_pc, out_store_data  out  32  head PC; bypassed raw rs2 value
- out_rd, out_wen  out  5, 1  head destination fields

## Operation
- Bypass before the operand mux: rs1_eff = (wb_valid && wb_rd!=0 && wb_rd==in_rs1_idx) ? wb_data : in_rs1. rs2_eff is formed the same way.
- Operand mux applies the sel encodings above. out_store_data always carries rs2_eff, whatever in_src2_sel is.
- An entry holds {op1, op2, func, pc, store_data, rd, wen}. wen is forced to 0 when rd==0.
- Storage is a head register (H) and a skid register (S), each with a valid bit.
- States by valid bits: EMPTY (H=0,S=0), ONE (H=1,S=0), FULL (H=1,S=1). S=1 with H=0 is illegal.
- in_ready is the registered value of !S.valid.
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- EMPTY + accept → ONE; new entry goes to H.
- ONE + accept + drain → ONE; H is replaced with the new entry.
- ONE + accept, no drain → FULL; new entry goes to S.
- ONE + drain, no accept → EMPTY.
- FULL + drain → ONE; S moves to H. in_valid is ignored because in_ready=0.
- FULL, no drain → hold; all outputs stable.
- out_valid = H.valid. alu_* and out_* reflect H. H data fields are don't-care when out_valid=0.
- flush: both valid bits are cleared at the edge, and any same-cycle accept is dropped. in_ready=1 on the next cycle. Flush takes priority over accept and drain.
- Reset mid-operation clears the valid bits immediately, without waiting for an edge.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on out_*/alu_* after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- Bypass and operand mux are combinational from in_* and wb_* into the entry registers. No combinational path from in_* to out_*.
- No combinational path from out_ready to in_ready.
- Reset values: H.valid=S.valid=0, in_ready=1, out_valid=0. alu_rs1, alu_rs2, out_pc and out_store_data are 0. alu_func=4'b0000, out_rd=0, out_wen=0.
- Output fields hold steady while out_valid && !out_ready.

## Test plan
- Back-to-back issue, out_ready=1. Send add (func 0000, sel 00/00, rs1=5, rs2=7), then sub (1000). Expect alu_rs1/rs2 = 5/7 then 5/7 on consecutive cycles, alu_func 0000 then 1000, and in_ready held at 1.
- Backpressure. Hold out_ready=0 and send three entries. Expect FULL after two, in_ready=0 in the following cycle, and the third entry held at the input. Raise out_ready and expect order 1, 2, 3 with no loss or duplication.
- Operand select. Use pc=0x80000000 with src1_sel=01 and src2_sel=10. Expect alu_rs1=0x80000000 and alu_rs2=4. Then src1_sel=11 and src2_sel=01 with imm=0xFFFFF800: expect 0 and 0xFFFFF800.
- Bypass. Drive wb_valid=1, wb_rd=3, wb_data=0xDEADBEEF with in_rs1_idx=3, in_rs1=0x11. Expect alu_rs1=0xDEADBEEF. Repeat with wb_rd=0 and expect 0x11. Store-data bypass from rs2 must behave the same way.
- Flush while FULL, with in_valid=1 in the same cycle. Expect out_valid=0 next cycle, in_ready=1, and the flushed-cycle input never appears.
- Async reset asserted mid-cycle while FULL. Expect out_valid=0 and all outputs at reset values before the next clk edge. After release, the first accepted entry appears after 1 cycle.
